reset_sequencer: RTL and testbench

//  Multi-source, multi-domain reset controller. It is the parametrised successor to the

---
 rtl/reset_sequencer.sv | 178 +++++++++++++++++
 tb/tb_reset_sequencer.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - multi-source reset synchronizer, extender and staggered domain releaser
//
// Purpose:
//   Each async reset request is synchronized separately and then ORed with a software request.
//   All domain resets assert together. Release begins only after NUM_EXTEND_CYCLES
//   consecutive idle cycles. Domains then release one at a time, domain 0 first, with
//   STAGE_GAP_CYCLES between releases. Any request that arrives before the sequence
//   completes re-asserts every domain.
//
// Ports:
//   sync_clk           sole clock
//   reset_n            synchronous active-low local reset
//   reset_req_async    NUM_SOURCES async reset requests, active-high
//   sw_reset_req       sync_clk-domain reset request, active-high
//   domain_reset       NUM_DOMAINS registered per-domain resets, active-high
//   all_released       high only while every domain is released
//   busy               high while asserting or releasing
//   reset_cause        (RST_SEQ_CAUSE_EN) {sw, synced sources} captured when leaving run
//   reset_event_count  (RST_SEQ_CAUSE_EN) saturating count of run -> assert transitions
//
// Optional feature macro: RST_SEQ_CAUSE_EN
module reset_sequencer #(
  parameter int NUM_SOURCES       = 2,
  parameter int NUM_DOMAINS       = 4,
  parameter int NUM_SYNC_STAGES   = 2,
  parameter int NUM_EXTEND_CYCLES = 4,
  parameter int STAGE_GAP_CYCLES  = 2
) (
  input  logic                   sync_clk,
  input  logic                   reset_n,
  input  logic [NUM_SOURCES-1:0] reset_req_async,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] domain_reset,
  output logic                   all_released,
  output logic                   busy
`ifdef RST_SEQ_CAUSE_EN
  ,
  output logic [NUM_SOURCES:0]   reset_cause,
  output logic [7:0]             reset_event_count
`endif
);

  localparam int CNT_MAX = (NUM_EXTEND_CYCLES > STAGE_GAP_CYCLES) ? NUM_EXTEND_CYCLES
                                                                   : STAGE_GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  typedef enum logic [1:0] {
    ST_ASSERT  = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W-1:0]       idx_next;
  logic [NUM_DOMAINS-1:0] dom_next;

  logic [NUM_SOURCES-1:0][NUM_SYNC_STAGES-1:0] sync_q;
  logic [NUM_SOURCES-1:0]                      synced_req;
  logic                                        req_any;

  // Sync chains reset to 1 so that a local reset looks like a live request until
  // NUM_SYNC_STAGES clean samples have flushed through.
  always_ff @(posedge sync_clk) begin
    for (int s = 0; s < NUM_SOURCES; s++) begin
      if (!reset_n) begin
        sync_q[s] <= '1;
      end else begin
        sync_q[s] <= {sync_q[s][NUM_SYNC_STAGES-2:0], reset_req_async[s]};
      end
    end
  end

  always_comb begin
    synced_req = '0;
    for (int s = 0; s < NUM_SOURCES; s++) begin
      synced_req[s] = sync_q[s][NUM_SYNC_STAGES-1];
    end
  end

  assign req_any = (|synced_req) | sw_reset_req;

  // cnt counts idle cycles in ASSERT and gap cycles in RELEASE. A request seen in
  // any state restarts the whole sequence with every domain asserted.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    idx_next   = idx;
    dom_next   = domain_reset;
    case (state)
      ST_ASSERT: begin
        dom_next = '1;
        if (req_any) begin
          cnt_next = '0;
        end else if (int'(cnt) >= NUM_EXTEND_CYCLES) begin
          cnt_next    = '0;
          idx_next    = '0;
          dom_next[0] = 1'b0;
          state_next  = (NUM_DOMAINS == 1) ? ST_RUN : ST_RELEASE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        if (req_any) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
          dom_next   = '1;
        end else if (int'(cnt) + 1 >= STAGE_GAP_CYCLES) begin
          cnt_next           = '0;
          idx_next           = idx + IDX_W'(1);
          dom_next[idx_next] = 1'b0;
          if (int'(idx) + 2 >= NUM_DOMAINS) begin
            state_next = ST_RUN;
          end
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      ST_RUN: begin
        dom_next = '0;
        if (req_any) begin
          state_next = ST_ASSERT;
          cnt_next   = '0;
          idx_next   = '0;
          dom_next   = '1;
        end
      end
      default: begin
        state_next = ST_ASSERT;
        cnt_next   = '0;
        idx_next   = '0;
        dom_next   = '1;
      end
    endcase
  end

  // Status outputs are registered from the next state so they move on the same
  // edge as the state transition.
  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      state        <= ST_ASSERT;
      cnt          <= '0;
      idx          <= '0;
      domain_reset <= '1;
      all_released <= 1'b0;
      busy         <= 1'b1;
    end else begin
      state        <= state_next;
      cnt          <= cnt_next;
      idx          <= idx_next;
      domain_reset <= dom_next;
      all_released <= (state_next == ST_RUN);
      busy         <= (state_next != ST_RUN);
    end
  end

`ifdef RST_SEQ_CAUSE_EN
  // Only RUN -> ASSERT counts as an event; the start-up assert after reset_n does not.
  always_ff @(posedge sync_clk) begin
    if (!reset_n) begin
      reset_cause       <= '0;
      reset_event_count <= '0;
    end else if (state == ST_RUN && req_any) begin
      reset_cause <= {sw_reset_req, synced_req};
      if (reset_event_count != 8'hFF) begin
        reset_event_count <= reset_event_count + 8'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - randomized self-checking bench for reset_sequencer
`timescale 1ns/1ps
module tb_reset_sequencer;
  localparam int NS = 2;
  localparam int ND = 4;
  localparam int S  = 2;
  localparam int E  = 4;
  localparam int G  = 2;
  localparam int RUN_L = E + 1 + (ND - 1) * G;

  logic          clk;
  logic          reset_n;
  logic [NS-1:0] req;
  logic          sw;
  logic [ND-1:0] dom;
  logic          all_rel;
  logic          busy;
  logic [0:0]    dom1;
  logic          all_rel1;
  logic          busy1;
`ifdef RST_SEQ_CAUSE_EN
  logic [NS:0]   cause;
  logic [7:0]    evcnt;
  logic [1:0]    cause1;
  logic [7:0]    evcnt1;
`endif

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  // Reference model: run_len is the number of consecutive edges with no request;
  // domain k is released once run_len reaches E+1+k*G.
  logic [NS-1:0] samp[$];
  int            run_len;
  int            run_len1;
  logic [NS:0]   m_cause;
  int            m_count;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  reset_sequencer #(
    .NUM_SOURCES(NS), .NUM_DOMAINS(ND), .NUM_SYNC_STAGES(S),
    .NUM_EXTEND_CYCLES(E), .STAGE_GAP_CYCLES(G)
  ) dut (
    .sync_clk(clk), .reset_n(reset_n), .reset_req_async(req), .sw_reset_req(sw),
    .domain_reset(dom), .all_released(all_rel), .busy(busy)
`ifdef RST_SEQ_CAUSE_EN
    , .reset_cause(cause), .reset_event_count(evcnt)
`endif
  );

  reset_sequencer #(
    .NUM_SOURCES(1), .NUM_DOMAINS(1), .NUM_SYNC_STAGES(S),
    .NUM_EXTEND_CYCLES(0), .STAGE_GAP_CYCLES(1)
  ) dut_sweep (
    .sync_clk(clk), .reset_n(reset_n), .reset_req_async(req[0:0]), .sw_reset_req(sw),
    .domain_reset(dom1), .all_released(all_rel1), .busy(busy1)
`ifdef RST_SEQ_CAUSE_EN
    , .reset_cause(cause1), .reset_event_count(evcnt1)
`endif
  );

  function automatic logic [ND-1:0] exp_dom(input int len);
    logic [ND-1:0] r;
    for (int k = 0; k < ND; k++) r[k] = (len < E + 1 + k * G);
    return r;
  endfunction

  task automatic cmp(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model_edge();
    logic [NS-1:0] synced;
    logic          req_any;
    logic          req_any1;
    if (!reset_n) begin
      samp.delete();
      for (int i = 0; i < S; i++) samp.push_back('1);
      run_len  = 0;
      run_len1 = 0;
      m_cause  = '0;
      m_count  = 0;
    end else begin
      synced = samp[0];
      samp.push_back(req);
      void'(samp.pop_front());
      req_any  = (|synced) | sw;
      req_any1 = synced[0] | sw;
      if (req_any) begin
        if (run_len >= RUN_L) begin
          m_cause = {sw, synced};
          m_count = (m_count < 255) ? m_count + 1 : 255;
        end
        run_len = 0;
      end else if (run_len < 100000) begin
        run_len++;
      end
      if (req_any1) run_len1 = 0;
      else if (run_len1 < 100000) run_len1++;
    end
  endtask

  task automatic check_outputs();
    cmp("domain_reset", 32'(dom), 32'(exp_dom(run_len)));
    cmp("all_released", 32'(all_rel), 32'(run_len >= RUN_L));
    cmp("busy", 32'(busy), 32'(run_len < RUN_L));
    cmp("sweep_domain_reset", 32'(dom1), 32'(run_len1 < 1));
    cmp("sweep_all_released", 32'(all_rel1), 32'(run_len1 >= 1));
    cmp("sweep_busy", 32'(busy1), 32'(run_len1 < 1));
`ifdef RST_SEQ_CAUSE_EN
    cmp("reset_cause", 32'(cause), 32'(m_cause));
    cmp("reset_event_count", 32'(evcnt), 32'(m_count));
`endif
  endtask

  task automatic step(input logic rn, input logic [NS-1:0] r, input logic s);
    reset_n = rn;
    req     = r;
    sw      = s;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, '0, 1'b0);
  endtask

  logic [ND-1:0] pwr_tab [13];

  initial begin
    pwr_tab = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hF, 4'hE, 4'hE, 4'hC, 4'hC, 4'h8, 4'h8, 4'h0};
    reset_n = 1'b0;
    req     = '0;
    sw      = 1'b0;

    // Power-up: reset values, then the fixed release staircase.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b0);
      cmp("rst_domain", 32'(dom), 32'hF);
      cmp("rst_all_released", 32'(all_rel), 32'h0);
      cmp("rst_busy", 32'(busy), 32'h1);
    end
    for (int i = 0; i < 13; i++) begin
      step(1'b1, '0, 1'b0);
      cmp("pwr_seq", 32'(dom), 32'(pwr_tab[i]));
    end
    cmp("pwr_all_released", 32'(all_rel), 32'h1);
    idle(3);

    // Async pulse on source 1 from RUN.
    step(1'b1, 2'b10, 1'b0);
    cmp("async_not_yet", 32'(dom), 32'h0);
    step(1'b1, '0, 1'b0);
    cmp("async_not_yet2", 32'(dom), 32'h0);
    step(1'b1, '0, 1'b0);
    cmp("async_asserted", 32'(dom), 32'hF);
    idle(16);

    // Abort mid-release with a software pulse at 1100.
    step(1'b1, '0, 1'b1);
    for (int i = 0; i < 30 && exp_dom(run_len) != 4'b1100; i++) step(1'b1, '0, 1'b0);
    cmp("reach_1100", 32'(dom), 32'hC);
    step(1'b1, '0, 1'b1);
    cmp("abort_all_high", 32'(dom), 32'hF);
    idle(16);

    // Extend restart: source 0 toggles with 2-cycle gaps.
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'b01, 1'b0);
      step(1'b1, 2'b01, 1'b0);
      step(1'b1, 2'b00, 1'b0);
      step(1'b1, 2'b00, 1'b0);
    end
    idle(16);

    // Local reset during RELEASE.
    step(1'b1, '0, 1'b1);
    for (int i = 0; i < 30 && exp_dom(run_len) != 4'b1110; i++) step(1'b1, '0, 1'b0);
    cmp("reach_1110", 32'(dom), 32'hE);
    step(1'b0, '0, 1'b0);
    cmp("rstn_mid_domain", 32'(dom), 32'hF);
    cmp("rstn_mid_all_released", 32'(all_rel), 32'h0);
    cmp("rstn_mid_busy", 32'(busy), 32'h1);
    idle(16);

    // Randomized traffic with sparse requests and occasional local resets.
    for (int i = 0; i < 1500; i++) begin
      logic [NS-1:0] r;
      for (int b = 0; b < NS; b++) r[b] = ($urandom_range(0, 23) == 0);
      step(($urandom_range(0, 199) != 0), r, ($urandom_range(0, 39) == 0));
    end
    idle(16);

`ifdef RST_SEQ_CAUSE_EN
    for (int i = 0; i < 300; i++) begin
      step(1'b1, '0, 1'b1);
      idle(RUN_L);
    end
    cmp("count_saturated", 32'(evcnt), 32'd255);
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
